rf_rw_sequencer: RTL and testbench
==================================

// Module: rf_rw_sequencer
// PURPOSE
// - Consumer end of the dispatcher's per-register rw_queue push interface.
// - Holds one in-order FIFO of access tokens per matrix register {rvalid, wready, id}.
//   Each token grants register-file read/write access to the execution unit whose instruction id is at the FIFO head.
// - Returns per-register full backpressure to the dispatcher.
// - Sits between the dispatcher and the matrix RF ports of the execution units, enforcing RAW/WAR/WAW order per register.
// PARAMETERS
// - N_REGS        8                    number of matrix registers (one FIFO each)
// - DEPTH         4                    tokens per register FIFO, power of 2, >=2
// - ID_WIDTH      xif_pkg::X_ID_WIDTH  instruction id width
// - N_RD_PORTS    4                    RF read-request ports (exec-unit operand ports)
// - N_WR_PORTS    3                    RF write-request ports (one per exec unit)
// PORTS
// - clk_i             in   1                               clock
// - rst_i             in   1                               synchronous reset, active-high
// - rw_queue_entry_i  in   N_REGS x rw_queue_t             tokens {rvalid, wready, id} from dispatcher
// - rw_queue_push_i   in   N_REGS                          push token into FIFO r
// - rw_queue_full_o   out  N_REGS                          FIFO r holds DEPTH tokens
// - rd_req_i          in   N_RD_PORTS                      read access request
// - rd_reg_i          in   N_RD_PORTS x $clog2(N_REGS)     requested register
// - rd_id_i           in   N_RD_PORTS x ID_WIDTH           requester instruction id
// - rd_gnt_o          out  N_RD_PORTS                      read access granted (combinational)
// - rd_release_i      in   N_RD_PORTS                      read access finished; valid only while rd_gnt_o is high
// - wr_req_i / wr_reg_i / wr_id_i / wr_gnt_o / wr_release_i   same as rd_*, N_WR_PORTS wide
// - error_o           out  1                               sticky protocol error
// BEHAVIOUR
// - Reset (rst_i high at posedge):
//   - All FIFOs empty; head done-flags clear.
//   - rw_queue_full_o=0, rd_gnt_o=0, wr_gnt_o=0, error_o=0.
//   - Reset mid-operation discards all tokens; grants drop the next cycle.
// - Per-register state:
//   - wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap); count ($clog2(DEPTH)+1 bits).
//   - Head flags rd_done_q, wr_done_q.
// - rw_queue_full_o[r] = (count_q[r]==DEPTH); registered value only, no same-cycle pop credit.
// - Push:
//   - Token written at wr_ptr on rw_queue_push_i[r] && !full.
//   - Push while full: token dropped, error_o set, FIFO unchanged.
//   - Push of a token with rvalid=wready=0: dropped, error_o set.
// - Head visibility: a pushed token becomes head-eligible the cycle after the push (1-cycle latency).
// - Read grant: rd_gnt_o[p] = rd_req_i[p] && count[r]>0 && head.rvalid && !rd_done_q[r] && head.id==rd_id_i[p], where r=rd_reg_i[p].
//   - Several ports matching the same head: only the lowest-indexed port is granted.
// - Write grant: same rule using head.wready / wr_done_q.
//   - Read and write grant on the same head may be issued in the same cycle.
// - Release:
//   - rd_release_i[p] && rd_gnt_o[p] sets rd_done_q[r]; same for the write side.
//   - Release without grant: ignored, error_o set.
// - Pop: head retires when every flagged access is done, counting same-cycle releases.
//   - (!head.rvalid || rd_done || rd_rel) && (!head.wready || wr_done || wr_rel).
//   - On pop: rd_ptr++, done flags clear, and the next head is eligible the following cycle.
// - Simultaneous push and pop on the same register: count unchanged, both pointers advance.
//   - Allowed only when not full at the cycle start.
// - Grants never target a non-head token; a younger id matching deeper in the FIFO stalls.
// - Tokens for different registers are fully independent; no cross-register ordering.
// - error_o is cleared only by reset.
// CONFIGURATION
// - RF_RW_SEQ_BYPASS_EN defined:
//   - Push into an empty FIFO with no retirement that cycle is head-eligible in the same cycle.
//   - Grant is combinational from rw_queue_entry_i.
//   - Push-to-grant latency 0.
// - RF_RW_SEQ_BYPASS_EN undefined: push-to-grant latency 1 cycle; no combinational path from rw_queue_* inputs to grants.
// TESTING
// - Reset: push r2 {rvalid,id=5} then rst_i one cycle -> count 0, full_o=0, rd req id5 on r2 -> rd_gnt_o=0.
// - RAW order: push r1 {wready,id3} then {rvalid,id4}.
//   - rd req id4 -> no grant; wr req id3 -> grant, release.
//   - Next cycle rd id4 -> grant.
// - Full: 4 pushes to r0 -> full_o[0]=1; 5th push -> dropped, error_o=1.
//   - Pop+push in the same cycle at count 3 -> count 3, full stays 0.
// - Dual access: head {rvalid,wready,id7} on r6.
//   - Rd and wr granted in the same cycle.
//   - Rd released -> no pop; wr released -> pop, count decrements.
// - Port priority: rd ports 1 and 3 both request r4 id2 -> rd_gnt_o=4'b0010.
//   - Release on port 3 -> ignored, error_o=1.
// - Bypass: empty r5, push {rvalid,id1} with rd req id1 the same cycle.
//   - Grant in cycle 0 with RF_RW_SEQ_BYPASS_EN defined, cycle 1 without.

Source files
------------

// File: rtl/rf_rw_sequencer_if.sv
// Purpose: bundles the dispatcher push side and the exec-unit RF access ports of rf_rw_sequencer.
// Latency: wires only; timing is set by the sequencer.
// Backpressure: rw_queue_full_o per register toward the dispatcher; grants gate the exec-unit ports.
interface rf_rw_sequencer_if #(
   parameter int N_REGS     = 8,
   parameter int ID_WIDTH   = 4,
   parameter int N_RD_PORTS = 4,
   parameter int N_WR_PORTS = 3
);
   localparam int REG_W = $clog2(N_REGS);
   localparam int ENT_W = ID_WIDTH + 2;

   // Token layout is {rvalid, wready, id}, rvalid in the MSB.
   logic [N_REGS-1:0][ENT_W-1:0]         rw_queue_entry_i;
   logic [N_REGS-1:0]                    rw_queue_push_i;
   logic [N_REGS-1:0]                    rw_queue_full_o;

   logic [N_RD_PORTS-1:0]                rd_req_i;
   logic [N_RD_PORTS-1:0][REG_W-1:0]     rd_reg_i;
   logic [N_RD_PORTS-1:0][ID_WIDTH-1:0]  rd_id_i;
   logic [N_RD_PORTS-1:0]                rd_gnt_o;
   logic [N_RD_PORTS-1:0]                rd_release_i;

   logic [N_WR_PORTS-1:0]                wr_req_i;
   logic [N_WR_PORTS-1:0][REG_W-1:0]     wr_reg_i;
   logic [N_WR_PORTS-1:0][ID_WIDTH-1:0]  wr_id_i;
   logic [N_WR_PORTS-1:0]                wr_gnt_o;
   logic [N_WR_PORTS-1:0]                wr_release_i;

   modport master (
      output rw_queue_entry_i, rw_queue_push_i,
      input  rw_queue_full_o,
      output rd_req_i, rd_reg_i, rd_id_i, rd_release_i,
      input  rd_gnt_o,
      output wr_req_i, wr_reg_i, wr_id_i, wr_release_i,
      input  wr_gnt_o
   );

   modport slave (
      input  rw_queue_entry_i, rw_queue_push_i,
      output rw_queue_full_o,
      input  rd_req_i, rd_reg_i, rd_id_i, rd_release_i,
      output rd_gnt_o,
      input  wr_req_i, wr_reg_i, wr_id_i, wr_release_i,
      output wr_gnt_o
   );
endinterface

// File: rtl/rf_rw_sequencer.sv
// Purpose: per-register in-order token FIFOs granting RF read/write access to the id at each head.
// Latency: push-to-grant 1 cycle (0 with RF_RW_SEQ_BYPASS_EN defined); grants are combinational from requests.
// Backpressure: rw_queue_full_o[r] is the registered "FIFO r holds DEPTH tokens"; pushes while full are dropped.
module rf_rw_sequencer #(
   parameter int N_REGS     = 8,
   parameter int DEPTH      = 4,
   parameter int ID_WIDTH   = 4,
   parameter int N_RD_PORTS = 4,
   parameter int N_WR_PORTS = 3
) (
   input  logic            clk_i,
   input  logic            rst_i,
   rf_rw_sequencer_if.slave bus,
   output logic            error_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int REG_W = $clog2(N_REGS);

   typedef struct packed {
      logic                rvalid;
      logic                wready;
      logic [ID_WIDTH-1:0] id;
   } rw_queue_t;

   rw_queue_t [N_REGS-1:0]           entry;
   rw_queue_t                        mem_q [N_REGS][DEPTH];
   logic [N_REGS-1:0][PTR_W-1:0]     wr_ptr_q;
   logic [N_REGS-1:0][PTR_W-1:0]     rd_ptr_q;
   logic [N_REGS-1:0][PTR_W:0]       count_q;
   logic [N_REGS-1:0]                rd_done_q;
   logic [N_REGS-1:0]                wr_done_q;
   logic                             error_q;

   rw_queue_t [N_REGS-1:0]           head;
   logic [N_REGS-1:0]                head_vld, full, push_ok, push_err, pop;
   logic [N_REGS-1:0]                rd_taken, wr_taken, rd_rel, wr_rel;
   logic [N_RD_PORTS-1:0]            rd_gnt;
   logic [N_WR_PORTS-1:0]            wr_gnt;
   logic                             rel_err;

   assign entry = bus.rw_queue_entry_i;

   // Push qualification and head selection; the bypass build lets a push into an empty FIFO be the head at once.
   always_comb begin
      full     = '0;
      push_ok  = '0;
      push_err = '0;
      head     = '0;
      head_vld = '0;
      for (int r = 0; r < N_REGS; r++) begin
         full[r]     = (count_q[r] == (PTR_W+1)'(DEPTH));
         push_ok[r]  = bus.rw_queue_push_i[r] && !full[r] && (entry[r].rvalid || entry[r].wready);
         push_err[r] = bus.rw_queue_push_i[r] && !push_ok[r];
`ifdef RF_RW_SEQ_BYPASS_EN
         if (count_q[r] == '0) begin
            head[r]     = entry[r];
            head_vld[r] = push_ok[r];
         end else begin
            head[r]     = mem_q[r][rd_ptr_q[r]];
            head_vld[r] = 1'b1;
         end
`else
         head[r]     = mem_q[r][rd_ptr_q[r]];
         head_vld[r] = (count_q[r] != '0);
`endif
      end
   end

   // Grants go to the lowest-indexed port matching the head id; releases are only honoured on granted ports.
   always_comb begin
      logic [REG_W-1:0] rr;
      rr       = '0;
      rd_gnt   = '0;
      wr_gnt   = '0;
      rd_taken = '0;
      wr_taken = '0;
      rd_rel   = '0;
      wr_rel   = '0;
      rel_err  = 1'b0;
      for (int p = 0; p < N_RD_PORTS; p++) begin
         rr = bus.rd_reg_i[p];
         if (bus.rd_req_i[p] && head_vld[rr] && head[rr].rvalid && !rd_done_q[rr] &&
             (head[rr].id == bus.rd_id_i[p]) && !rd_taken[rr]) begin
            rd_gnt[p]    = 1'b1;
            rd_taken[rr] = 1'b1;
         end
         if (bus.rd_release_i[p]) begin
            if (rd_gnt[p]) rd_rel[rr] = 1'b1;
            else           rel_err    = 1'b1;
         end
      end
      for (int p = 0; p < N_WR_PORTS; p++) begin
         rr = bus.wr_reg_i[p];
         if (bus.wr_req_i[p] && head_vld[rr] && head[rr].wready && !wr_done_q[rr] &&
             (head[rr].id == bus.wr_id_i[p]) && !wr_taken[rr]) begin
            wr_gnt[p]    = 1'b1;
            wr_taken[rr] = 1'b1;
         end
         if (bus.wr_release_i[p]) begin
            if (wr_gnt[p]) wr_rel[rr] = 1'b1;
            else           rel_err    = 1'b1;
         end
      end
   end

   // A head retires once every access it flags is done, counting releases arriving this cycle.
   always_comb begin
      pop = '0;
      for (int r = 0; r < N_REGS; r++) begin
         pop[r] = head_vld[r] &&
                  (!head[r].rvalid || rd_done_q[r] || rd_rel[r]) &&
                  (!head[r].wready || wr_done_q[r] || wr_rel[r]);
      end
   end

   // Token storage; contents are don't-care until counted, so no reset.
   always_ff @(posedge clk_i) begin
      for (int r = 0; r < N_REGS; r++) begin
         if (push_ok[r]) mem_q[r][wr_ptr_q[r]] <= entry[r];
      end
   end

   // Pointers, occupancy, head done-flags and the sticky error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_done_q <= '0;
         wr_done_q <= '0;
         error_q   <= 1'b0;
      end else begin
         for (int r = 0; r < N_REGS; r++) begin
            if (push_ok[r]) wr_ptr_q[r] <= wr_ptr_q[r] + PTR_W'(1);
            if (pop[r])     rd_ptr_q[r] <= rd_ptr_q[r] + PTR_W'(1);
            count_q[r] <= count_q[r] + {{PTR_W{1'b0}}, push_ok[r]} - {{PTR_W{1'b0}}, pop[r]};
            if (pop[r]) begin
               rd_done_q[r] <= 1'b0;
               wr_done_q[r] <= 1'b0;
            end else begin
               if (rd_rel[r]) rd_done_q[r] <= 1'b1;
               if (wr_rel[r]) wr_done_q[r] <= 1'b1;
            end
         end
         if ((|push_err) || rel_err) error_q <= 1'b1;
      end
   end

   assign bus.rw_queue_full_o = full;
   assign bus.rd_gnt_o        = rd_gnt;
   assign bus.wr_gnt_o        = wr_gnt;
   assign error_o             = error_q;
endmodule

// File: tb/tb_rf_rw_sequencer.sv
// Purpose: directed self-checking bench for rf_rw_sequencer (expected values queued at drive time).
// Latency: expected push-to-grant latency follows RF_RW_SEQ_BYPASS_EN.
// Backpressure: exercises full drop, pop+push at count 3 and sticky error paths.
module tb_rf_rw_sequencer;
   localparam int N_REGS   = 8;
   localparam int DEPTH    = 4;
   localparam int ID_WIDTH = 4;
   localparam int N_RD     = 4;
   localparam int N_WR     = 3;
`ifdef RF_RW_SEQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_i = 1'b1;
   logic error_o;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   rf_rw_sequencer_if #(.N_REGS(N_REGS), .ID_WIDTH(ID_WIDTH), .N_RD_PORTS(N_RD), .N_WR_PORTS(N_WR)) bus ();

   rf_rw_sequencer #(.N_REGS(N_REGS), .DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH),
                     .N_RD_PORTS(N_RD), .N_WR_PORTS(N_WR)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .bus     (bus),
      .error_o (error_o)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus.rw_queue_entry_i = '0;
      bus.rw_queue_push_i  = '0;
      bus.rd_req_i         = '0;
      bus.rd_reg_i         = '0;
      bus.rd_id_i          = '0;
      bus.rd_release_i     = '0;
      bus.wr_req_i         = '0;
      bus.wr_reg_i         = '0;
      bus.wr_id_i          = '0;
      bus.wr_release_i     = '0;
   endtask

   task automatic push_tok(input int r, input int rv, input int wr, input int id);
      bus.rw_queue_push_i[r]  = 1'b1;
      bus.rw_queue_entry_i[r] = {1'(rv), 1'(wr), ID_WIDTH'(id)};
   endtask

   task automatic drive_rd(input int p, input int r, input int id, input int rel);
      bus.rd_req_i[p]     = 1'b1;
      bus.rd_reg_i[p]     = 3'(r);
      bus.rd_id_i[p]      = ID_WIDTH'(id);
      bus.rd_release_i[p] = 1'(rel);
   endtask

   task automatic drive_wr(input int p, input int r, input int id, input int rel);
      bus.wr_req_i[p]     = 1'b1;
      bus.wr_reg_i[p]     = 3'(r);
      bus.wr_id_i[p]      = ID_WIDTH'(id);
      bus.wr_release_i[p] = 1'(rel);
   endtask

   // Commit the current cycle, then return inputs to idle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
   endtask

   task automatic expect_v(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic compare(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL sb_underflow observed=%0h expected=<queued value>", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      rst_i = 1'b1;
      step();
      step();
      // Reset state
      expect_v("rst_full", 32'h0);
      expect_v("rst_err",  32'h0);
      expect_v("rst_gnt",  32'h0);
      sample();
      compare(32'(bus.rw_queue_full_o));
      compare(32'(error_o));
      compare(32'({bus.wr_gnt_o, bus.rd_gnt_o}));
      rst_i = 1'b0;
      step();

      // Mid-operation reset discards the token
      push_tok(2, 1, 0, 5);
      step();
      rst_i = 1'b1;
      drive_rd(0, 2, 5, 0);
      expect_v("pre_rst_gnt", 32'h1);
      sample();
      compare(32'(bus.rd_gnt_o));
      step();
      rst_i = 1'b0;
      drive_rd(0, 2, 5, 0);
      expect_v("post_rst_gnt",  32'h0);
      expect_v("post_rst_cnt",  32'h0);
      expect_v("post_rst_full", 32'h0);
      sample();
      compare(32'(bus.rd_gnt_o));
      compare(32'(dut.count_q[2]));
      compare(32'(bus.rw_queue_full_o));
      step();

      // RAW order on r1
      push_tok(1, 0, 1, 3);
      step();
      push_tok(1, 1, 0, 4);
      step();
      drive_rd(0, 1, 4, 0);
      drive_wr(0, 1, 3, 1);
      expect_v("raw_rd_stall", 32'h0);
      expect_v("raw_wr_gnt",   32'h1);
      sample();
      compare(32'(bus.rd_gnt_o));
      compare(32'(bus.wr_gnt_o));
      step();
      drive_rd(0, 1, 4, 1);
      expect_v("raw_rd_gnt", 32'h1);
      sample();
      compare(32'(bus.rd_gnt_o));
      step();
      expect_v("raw_cnt", 32'h0);
      sample();
      compare(32'(dut.count_q[1]));
      step();

      // Full, overflow drop, pop+push at count 3
      for (int k = 0; k < DEPTH; k++) begin
         push_tok(0, 1, 0, k);
         step();
      end
      expect_v("full_set", 32'h1);
      expect_v("full_err_clr", 32'h0);
      sample();
      compare(32'(bus.rw_queue_full_o[0]));
      compare(32'(error_o));
      step();
      push_tok(0, 1, 0, 9);
      step();
      expect_v("ovf_err", 32'h1);
      expect_v("ovf_cnt", 32'h4);
      sample();
      compare(32'(error_o));
      compare(32'(dut.count_q[0]));
      step();
      drive_rd(0, 0, 0, 1);
      expect_v("pop0_gnt", 32'h1);
      sample();
      compare(32'(bus.rd_gnt_o));
      step();
      expect_v("c3_full", 32'h0);
      expect_v("c3_cnt",  32'h3);
      sample();
      compare(32'(bus.rw_queue_full_o[0]));
      compare(32'(dut.count_q[0]));
      step();
      drive_rd(0, 0, 1, 1);
      push_tok(0, 1, 0, 10);
      expect_v("pp_gnt", 32'h1);
      sample();
      compare(32'(bus.rd_gnt_o));
      step();
      expect_v("pp_cnt",  32'h3);
      expect_v("pp_full", 32'h0);
      sample();
      compare(32'(dut.count_q[0]));
      compare(32'(bus.rw_queue_full_o[0]));
      step();
      drive_rd(0, 0, 3, 0);
      drive_rd(1, 0, 2, 0);
      expect_v("nonhead_stall", 32'h2);
      sample();
      compare(32'(bus.rd_gnt_o));
      step();

      // Token with neither access flagged is dropped
      do_reset();
      push_tok(3, 0, 0, 1);
      expect_v("zero_err_before", 32'h0);
      sample();
      compare(32'(error_o));
      step();
      expect_v("zero_err", 32'h1);
      expect_v("zero_cnt", 32'h0);
      sample();
      compare(32'(error_o));
      compare(32'(dut.count_q[3]));
      step();

      // Dual access head on r6
      do_reset();
      push_tok(6, 1, 1, 7);
      step();
      drive_rd(0, 6, 7, 1);
      drive_wr(0, 6, 7, 0);
      expect_v("dual_rd", 32'h1);
      expect_v("dual_wr", 32'h1);
      sample();
      compare(32'(bus.rd_gnt_o));
      compare(32'(bus.wr_gnt_o));
      step();
      expect_v("dual_nopop", 32'h1);
      sample();
      compare(32'(dut.count_q[6]));
      step();
      drive_rd(0, 6, 7, 0);
      drive_wr(0, 6, 7, 1);
      expect_v("dual_rd_done", 32'h0);
      expect_v("dual_wr2",     32'h1);
      sample();
      compare(32'(bus.rd_gnt_o));
      compare(32'(bus.wr_gnt_o));
      step();
      expect_v("dual_pop", 32'h0);
      sample();
      compare(32'(dut.count_q[6]));
      step();

      // Port priority and release without grant
      do_reset();
      push_tok(4, 1, 0, 2);
      step();
      drive_rd(1, 4, 2, 0);
      drive_rd(3, 4, 2, 1);
      expect_v("prio_gnt", 32'h2);
      expect_v("prio_err_before", 32'h0);
      sample();
      compare(32'(bus.rd_gnt_o));
      compare(32'(error_o));
      step();
      expect_v("prio_err", 32'h1);
      expect_v("prio_cnt", 32'h1);
      sample();
      compare(32'(error_o));
      compare(32'(dut.count_q[4]));
      step();

      // Push-to-grant latency on empty r5
      push_tok(5, 1, 0, 1);
      drive_rd(0, 5, 1, 0);
      expect_v("byp_c0", 32'(BYP));
      sample();
      compare(32'(bus.rd_gnt_o));
      step();
      drive_rd(0, 5, 1, 1);
      expect_v("byp_c1", 32'h1);
      sample();
      compare(32'(bus.rd_gnt_o));
      step();
      expect_v("byp_cnt", 32'h0);
      sample();
      compare(32'(dut.count_q[5]));
      step();

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
